// File: rtl/memory_access_stage_if.sv
// Data-memory request/response bus between the M stage and data memory.
// Request side is combinational from the stage; response is same-cycle capable.
// dmem_ready completes the outstanding request; the master holds it until then.
interface memory_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  // Pipeline stage side
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ready
  );

  // Memory side
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/memory_access_stage.sv
// M stage of the RV32I pipeline: byte/half/word loads and stores, drives the M/W register.
// Latency: zero-wait access completes in 1 cycle; each memory wait cycle adds one (bubble per stall).
// Backpressure: stall_M freezes upstream while dmem_ready is low; aborted after TIMEOUT_CYCLES.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being aligned down.
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE2,
  input  logic        MemWriteE2,
  input  logic [1:0]  ResultSrcE2,
  input  logic [4:0]  RD_E2,
  input  logic [31:0] ALU_ResultE2,
  input  logic [31:0] WriteDataE2,
  input  logic [31:0] PCPlus4E2,
  input  logic [2:0]  LoadTypeE2,
  input  logic [2:0]  StoreTypeE2,
  memory_access_stage_if.master dmem,
  output logic        stall_M,
  output logic        bus_err_M,
  output logic        RegWriteW,
  output logic [4:0]  RD_W,
  output logic [31:0] ResultW
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        mem_op;
  logic        misalign;
  logic        timeout_hit;
  logic        abort;
  logic        kill;
  logic        req;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  store_strb;
  logic [31:0] result_sel;

  logic        regwrite_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;

  assign mem_op = MemWriteE2 | (ResultSrcE2 == 2'b01);

`ifdef MISALIGN_TRAP_EN
  // Misaligned halves (odd address) and words (any low bit set) trap
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      if (MemWriteE2) begin
        case (StoreTypeE2)
          3'b000:  misalign = 1'b0;
          3'b001:  misalign = ALU_ResultE2[0];
          default: misalign = |ALU_ResultE2[1:0];
        endcase
      end else begin
        case (LoadTypeE2)
          3'b000, 3'b100: misalign = 1'b0;
          3'b001, 3'b101: misalign = ALU_ResultE2[0];
          default:        misalign = |ALU_ResultE2[1:0];
        endcase
      end
    end
  end
`else
  // Low address bits below the access size are simply ignored
  assign misalign = 1'b0;
`endif

  // Ready on the timeout cycle wins, so abort only without ready
  assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign abort       = mem_op & timeout_hit & ~dmem.dmem_ready;
  assign kill        = abort | misalign;

  // FSM state and wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: enter WAIT on a stalled request, leave on ready or timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op & ~dmem.dmem_ready & ~kill) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (~mem_op | dmem.dmem_ready | timeout_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: request, stall and error pulse, all silenced during reset
  always_comb begin
    req       = mem_op & ~kill & ~rst;
    stall_M   = mem_op & ~dmem.dmem_ready & ~kill & ~rst;
    bus_err_M = kill & ~rst;
  end

  // Store lane steering: replicate data, enable only the addressed bytes
  always_comb begin
    store_data = WriteDataE2;
    store_strb = 4'b1111;
    case (StoreTypeE2)
      3'b000: begin
        store_data = {4{WriteDataE2[7:0]}};
        store_strb = 4'b0001 << ALU_ResultE2[1:0];
      end
      3'b001: begin
        store_data = {2{WriteDataE2[15:0]}};
        store_strb = ALU_ResultE2[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = WriteDataE2;
        store_strb = 4'b1111;
      end
    endcase
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & MemWriteE2;
  assign dmem.dmem_addr  = {ALU_ResultE2[31:2], 2'b00};
  assign dmem.dmem_wdata = store_data;
  assign dmem.dmem_wstrb = (req & MemWriteE2) ? store_strb : 4'b0000;

  // Load formatting: pick byte/half by address lane, then extend
  always_comb begin
    case (ALU_ResultE2[1:0])
      2'b00:   load_byte = dmem.dmem_rdata[7:0];
      2'b01:   load_byte = dmem.dmem_rdata[15:8];
      2'b10:   load_byte = dmem.dmem_rdata[23:16];
      default: load_byte = dmem.dmem_rdata[31:24];
    endcase
    load_half = ALU_ResultE2[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (LoadTypeE2)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'b0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'b0, load_half};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

  // Writeback result select; 11 falls back to the ALU result
  always_comb begin
    case (ResultSrcE2)
      2'b01:   result_sel = load_data;
      2'b10:   result_sel = PCPlus4E2;
      default: result_sel = ALU_ResultE2;
    endcase
  end

  // M/W register: bubble on stall, abort or trap; otherwise capture the instruction
  always_ff @(posedge clk) begin
    if (rst || stall_M || kill) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
    end else begin
      regwrite_q <= RegWriteE2;
      rd_q       <= RD_E2;
      result_q   <= result_sel;
    end
  end

  assign RegWriteW = regwrite_q;
  assign RD_W      = rd_q;
  assign ResultW   = result_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: loads, stores, wait states, timeout, reset.
// Expected M/W values are queued when each step is driven and checked after the edge.
// Memory responses (ready/rdata) are driven directly per step.
module tb_memory_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE2, MemWriteE2;
  logic [1:0]  ResultSrcE2;
  logic [4:0]  RD_E2;
  logic [31:0] ALU_ResultE2, WriteDataE2, PCPlus4E2;
  logic [2:0]  LoadTypeE2, StoreTypeE2;
  logic        stall_M, bus_err_M, RegWriteW;
  logic [4:0]  RD_W;
  logic [31:0] ResultW;

  memory_access_stage_if dmem_bus ();

  memory_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE2(RegWriteE2), .MemWriteE2(MemWriteE2), .ResultSrcE2(ResultSrcE2),
    .RD_E2(RD_E2), .ALU_ResultE2(ALU_ResultE2), .WriteDataE2(WriteDataE2),
    .PCPlus4E2(PCPlus4E2), .LoadTypeE2(LoadTypeE2), .StoreTypeE2(StoreTypeE2),
    .dmem(dmem_bus),
    .stall_M(stall_M), .bus_err_M(bus_err_M),
    .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
  } mw_t;

  mw_t sb_q[$];
  int  tests = 0;
  int  fails = 0;

  localparam mw_t BUBBLE = '{rw: 1'b0, rd: 5'd0, res: 32'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc4, input logic [2:0] lt, input logic [2:0] st);
    RegWriteE2 = rw; MemWriteE2 = mw; ResultSrcE2 = rs; RD_E2 = rd;
    ALU_ResultE2 = alu; WriteDataE2 = wd; PCPlus4E2 = pc4;
    LoadTypeE2 = lt; StoreTypeE2 = st;
  endtask

  // One cycle: drive response, check combinational outputs, then check M/W after the edge
  task automatic step(input string tag, input logic rdy, input logic [31:0] rdata, input mw_t exp,
                      input logic e_stall, input logic e_req, input logic e_err);
    mw_t e;
    dmem_bus.dmem_ready = rdy;
    dmem_bus.dmem_rdata = rdata;
    #1;
    chk({tag, ".stall"}, {31'b0, stall_M}, {31'b0, e_stall});
    chk({tag, ".req"},   {31'b0, dmem_bus.dmem_req}, {31'b0, e_req});
    chk({tag, ".err"},   {31'b0, bus_err_M}, {31'b0, e_err});
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".rw"},  {31'b0, RegWriteW}, {31'b0, e.rw});
    chk({tag, ".rd"},  {27'b0, RD_W}, {27'b0, e.rd});
    chk({tag, ".res"}, ResultW, e.res);
  endtask

  initial begin
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    // Reset with a load presented: no request or stall may escape
    rst = 1'b1;
    set_op(1, 0, 2'b01, 5'd5, 32'h100, 32'h0, 32'h0, 3'b010, 3'b010);
    step("rst0", 0, 32'h0, BUBBLE, 0, 0, 0);
    step("rst1", 0, 32'h0, BUBBLE, 0, 0, 0);
    rst = 1'b0;

    // LW zero-wait
    #1;
    chk("lw.addr",  dmem_bus.dmem_addr, 32'h100);
    chk("lw.wstrb", {28'b0, dmem_bus.dmem_wstrb}, 32'h0);
    chk("lw.we",    {31'b0, dmem_bus.dmem_we}, 32'h0);
    step("lw", 1, 32'hDEADBEEF, '{1'b1, 5'd5, 32'hDEADBEEF}, 0, 1, 0);

    // Byte and half loads with sign/zero extension
    set_op(1, 0, 2'b01, 5'd6, 32'h103, 32'h0, 32'h0, 3'b000, 3'b010);
    step("lb3", 1, 32'h80123456, '{1'b1, 5'd6, 32'hFFFFFF80}, 0, 1, 0);
    set_op(1, 0, 2'b01, 5'd6, 32'h103, 32'h0, 32'h0, 3'b100, 3'b010);
    step("lbu3", 1, 32'h80123456, '{1'b1, 5'd6, 32'h00000080}, 0, 1, 0);
    set_op(1, 0, 2'b01, 5'd7, 32'h100, 32'h0, 32'h0, 3'b000, 3'b010);
    step("lb0", 1, 32'h80123456, '{1'b1, 5'd7, 32'h00000056}, 0, 1, 0);
    set_op(1, 0, 2'b01, 5'd8, 32'h102, 32'h0, 32'h0, 3'b001, 3'b010);
    step("lh2", 1, 32'h80123456, '{1'b1, 5'd8, 32'hFFFF8012}, 0, 1, 0);
    set_op(1, 0, 2'b01, 5'd8, 32'h102, 32'h0, 32'h0, 3'b101, 3'b010);
    step("lhu2", 1, 32'h80123456, '{1'b1, 5'd8, 32'h00008012}, 0, 1, 0);
    set_op(1, 0, 2'b01, 5'd9, 32'h100, 32'h0, 32'h0, 3'b111, 3'b010);
    step("lrsv", 1, 32'h0BADF00D, '{1'b1, 5'd9, 32'h0BADF00D}, 0, 1, 0);

    // Non-memory ops: PC+4, ALU, and 11 falls back to ALU
    set_op(1, 0, 2'b10, 5'd1, 32'h55, 32'h0, 32'h1004, 3'b010, 3'b010);
    step("pc4", 0, 32'h0, '{1'b1, 5'd1, 32'h1004}, 0, 0, 0);
    set_op(1, 0, 2'b11, 5'd2, 32'h77, 32'h0, 32'h1008, 3'b010, 3'b010);
    step("rs11", 0, 32'h0, '{1'b1, 5'd2, 32'h77}, 0, 0, 0);

    // SH with three wait cycles
    set_op(0, 1, 2'b00, 5'd0, 32'h202, 32'h1234ABCD, 32'h0, 3'b010, 3'b001);
    #1;
    chk("sh.wdata", dmem_bus.dmem_wdata, 32'hABCDABCD);
    chk("sh.wstrb", {28'b0, dmem_bus.dmem_wstrb}, 32'hC);
    for (int i = 0; i < 3; i++) begin
      step("sh.wait", 0, 32'h0, BUBBLE, 1, 1, 0);
      chk("sh.we", {31'b0, dmem_bus.dmem_we}, 32'h1);
    end
    step("sh.done", 1, 32'h0, '{1'b0, 5'd0, 32'h202}, 0, 1, 0);

    // SB lane 1 and SW
    set_op(0, 1, 2'b00, 5'd0, 32'h201, 32'h000000EF, 32'h0, 3'b010, 3'b000);
    #1;
    chk("sb.wdata", dmem_bus.dmem_wdata, 32'hEFEFEFEF);
    chk("sb.wstrb", {28'b0, dmem_bus.dmem_wstrb}, 32'h2);
    step("sb", 1, 32'h0, '{1'b0, 5'd0, 32'h201}, 0, 1, 0);
    set_op(0, 1, 2'b00, 5'd0, 32'h204, 32'h11223344, 32'h0, 3'b010, 3'b010);
    #1;
    chk("sw.wdata", dmem_bus.dmem_wdata, 32'h11223344);
    chk("sw.wstrb", {28'b0, dmem_bus.dmem_wstrb}, 32'hF);
    step("sw", 1, 32'h0, '{1'b0, 5'd0, 32'h204}, 0, 1, 0);

    // Reset during WAIT of a store drops it; next LW completes normally
    set_op(0, 1, 2'b00, 5'd0, 32'h400, 32'h55667788, 32'h0, 3'b010, 3'b010);
    step("rsw.w0", 0, 32'h0, BUBBLE, 1, 1, 0);
    step("rsw.w1", 0, 32'h0, BUBBLE, 1, 1, 0);
    rst = 1'b1;
    #1;
    chk("rsw.wstrb", {28'b0, dmem_bus.dmem_wstrb}, 32'h0);
    step("rsw.rst", 0, 32'h0, BUBBLE, 0, 0, 0);
    rst = 1'b0;
    set_op(1, 0, 2'b01, 5'd3, 32'h104, 32'h0, 32'h0, 3'b010, 3'b010);
    step("rsw.lw", 1, 32'h11223344, '{1'b1, 5'd3, 32'h11223344}, 0, 1, 0);

    // Timeout: four stall cycles, then abort pulse, then back to IDLE
    set_op(1, 0, 2'b01, 5'd7, 32'h300, 32'h0, 32'h0, 3'b010, 3'b010);
    for (int i = 0; i < TO; i++) step("to.wait", 0, 32'h0, BUBBLE, 1, 1, 0);
    step("to.abort", 0, 32'h0, BUBBLE, 0, 0, 1);
    set_op(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 3'b010, 3'b010);
    step("to.after", 0, 32'h0, BUBBLE, 0, 0, 0);

    // Ready arriving on the timeout cycle completes the access
    set_op(1, 0, 2'b01, 5'd9, 32'h304, 32'h0, 32'h0, 3'b010, 3'b010);
    for (int i = 0; i < TO; i++) step("rw.wait", 0, 32'h0, BUBBLE, 1, 1, 0);
    step("rw.done", 1, 32'hCAFEF00D, '{1'b1, 5'd9, 32'hCAFEF00D}, 0, 1, 0);

    // Misaligned word load
    set_op(1, 0, 2'b01, 5'd4, 32'h101, 32'h0, 32'h0, 3'b010, 3'b010);
`ifdef MISALIGN_TRAP_EN
    step("mis.trap", 1, 32'h99887766, BUBBLE, 0, 0, 1);
`else
    #1;
    chk("mis.addr", dmem_bus.dmem_addr, 32'h100);
    step("mis.lw", 1, 32'h99887766, '{1'b1, 5'd4, 32'h99887766}, 0, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
